// File: rtl/mem_chunk_scheduler_pkg.sv
// Shared types and constants for the buffer-to-page-chunk request scheduler.
package mem_chunk_scheduler_pkg;

  localparam int unsigned NUM_STREAMS = 4;
  localparam int unsigned VADDR_BITS  = 48;
  localparam int unsigned SIZE_BITS   = 28;
  localparam int unsigned PAGE_BYTES  = 4096;
  localparam int unsigned PAGE_SHIFT  = $clog2(PAGE_BYTES);
  localparam int unsigned LEN_BITS    = PAGE_SHIFT + 1;
  localparam int unsigned STREAM_BITS = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int unsigned CALC_BITS   = SIZE_BITS + 1;

  typedef logic [VADDR_BITS-1:0]  vaddress_t;
  typedef logic [SIZE_BITS-1:0]   alloc_size_t;
  typedef logic [LEN_BITS-1:0]    req_len_t;
  typedef logic [STREAM_BITS-1:0] stream_id_t;

  typedef struct packed {
    vaddress_t  vaddr;
    req_len_t   len;
    stream_id_t stream;
    logic       last;
  } mem_req_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } sched_state_e;

  // Bytes up to the next page boundary, capped by what is left of the buffer.
  function automatic logic [CALC_BITS-1:0] chunk_bytes(input logic [PAGE_SHIFT-1:0] page_off,
                                                       input alloc_size_t remaining);
    logic [CALC_BITS-1:0] room;
    logic [CALC_BITS-1:0] rem;
    room = CALC_BITS'(PAGE_BYTES) - CALC_BITS'(page_off);
    rem  = CALC_BITS'(remaining);
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/mem_chunk_scheduler_round_robin_arbiter.sv
// Round-robin grant over a request vector; owns the rotating priority pointer.
module round_robin_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        request,
  input  logic                advance,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    int unsigned j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_valid && request[IDX_BITS'(j)]) begin
        grant_valid                = 1'b1;
        grant_idx                  = IDX_BITS'(j);
        grant[IDX_BITS'(j)]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == IDX_BITS'(N - 1)) ? '0 : IDX_BITS'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/mem_chunk_scheduler.sv
// Splits per-stream buffers into page-bounded requests, interleaved round-robin per chunk.
module mem_chunk_scheduler
  import mem_chunk_scheduler_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_STREAMS-1:0]            buf_valid,
  output logic [NUM_STREAMS-1:0]            buf_ready,
  input  logic [NUM_STREAMS*VADDR_BITS-1:0] buf_vaddr,
  input  logic [NUM_STREAMS*SIZE_BITS-1:0]  buf_size,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [VADDR_BITS-1:0]             req_vaddr,
  output logic [LEN_BITS-1:0]               req_len,
  output logic [STREAM_BITS-1:0]            req_stream,
  output logic                              req_last,
  output logic                              done_valid,
  output logic [STREAM_BITS-1:0]            done_stream
);

  sched_state_e state, state_n;

  logic [NUM_STREAMS-1:0] occupied, occupied_n;
  logic [NUM_STREAMS-1:0] calc_ok, calc_ok_n;
  logic [NUM_STREAMS-1:0] buf_ready_n;
  vaddress_t              cur_vaddr   [NUM_STREAMS];
  vaddress_t              cur_vaddr_n [NUM_STREAMS];
  alloc_size_t            remaining   [NUM_STREAMS];
  alloc_size_t            remaining_n [NUM_STREAMS];
  logic [CALC_BITS-1:0]   chunk_full  [NUM_STREAMS];
  req_len_t               chunk_len_q [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] chunk_last_q;

  mem_req_t   req_q, req_n;
  logic       req_valid_n;
  logic       done_valid_n;
  stream_id_t done_stream_n;

  logic [NUM_STREAMS-1:0] grant;
  stream_id_t             grant_idx;
  logic                   grant_valid;
  logic                   advance;

  // A slot may only be granted once its chunk registers reflect its current state.
  round_robin_arbiter #(
    .N        (NUM_STREAMS),
    .IDX_BITS (STREAM_BITS)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .request     (calc_ok),
    .advance     (advance),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      chunk_full[i] = chunk_bytes(cur_vaddr[i][PAGE_SHIFT-1:0], remaining[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    occupied_n    = occupied;
    calc_ok_n     = occupied;
    cur_vaddr_n   = cur_vaddr;
    remaining_n   = remaining;
    req_n         = req_q;
    req_valid_n   = req_valid;
    done_valid_n  = 1'b0;
    done_stream_n = done_stream;
    advance       = 1'b0;

    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (buf_valid[i] && buf_ready[i]) begin
        occupied_n[i]  = 1'b1;
        calc_ok_n[i]   = 1'b0;
        cur_vaddr_n[i] = buf_vaddr[i*VADDR_BITS +: VADDR_BITS];
        remaining_n[i] = buf_size[i*SIZE_BITS +: SIZE_BITS];
      end
    end

    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          advance = 1'b1;
          // Empty buffers complete straight from the grant without a request.
          if (remaining[grant_idx] == '0) begin
            occupied_n    = occupied_n & ~grant;
            calc_ok_n     = calc_ok_n & ~grant;
            done_valid_n  = 1'b1;
            done_stream_n = grant_idx;
          end else begin
            req_n = '{vaddr:  cur_vaddr[grant_idx],
                      len:    chunk_len_q[grant_idx],
                      stream: grant_idx,
                      last:   chunk_last_q[grant_idx]};
            req_valid_n = 1'b1;
            state_n     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          req_valid_n                 = 1'b0;
          state_n                     = S_IDLE;
          cur_vaddr_n[req_q.stream]   = cur_vaddr[req_q.stream] + VADDR_BITS'(req_q.len);
          remaining_n[req_q.stream]   = remaining[req_q.stream] - SIZE_BITS'(req_q.len);
          calc_ok_n[req_q.stream]     = 1'b0;
          if (req_q.last) begin
            occupied_n[req_q.stream] = 1'b0;
            done_valid_n             = 1'b1;
            done_stream_n            = req_q.stream;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    buf_ready_n = ~occupied_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied     <= '0;
      calc_ok      <= '0;
      buf_ready    <= '1;
      req_q        <= '0;
      req_valid    <= 1'b0;
      done_valid   <= 1'b0;
      done_stream  <= '0;
      chunk_last_q <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        cur_vaddr[i]   <= '0;
        remaining[i]   <= '0;
        chunk_len_q[i] <= '0;
      end
    end else begin
      occupied    <= occupied_n;
      calc_ok     <= calc_ok_n;
      buf_ready   <= buf_ready_n;
      req_q       <= req_n;
      req_valid   <= req_valid_n;
      done_valid  <= done_valid_n;
      done_stream <= done_stream_n;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        cur_vaddr[i]    <= cur_vaddr_n[i];
        remaining[i]    <= remaining_n[i];
        chunk_len_q[i]  <= LEN_BITS'(chunk_full[i]);
        chunk_last_q[i] <= (chunk_full[i] == CALC_BITS'(remaining[i]));
      end
    end
  end

  assign req_vaddr  = req_q.vaddr;
  assign req_len    = req_q.len;
  assign req_stream = req_q.stream;
  assign req_last   = req_q.last;

endmodule

// File: tb/tb_mem_chunk_scheduler.sv
// Directed and randomized bench for mem_chunk_scheduler with a page-splitting reference model.
module tb_mem_chunk_scheduler;
  import mem_chunk_scheduler_pkg::*;

  localparam int unsigned NS = NUM_STREAMS;
  localparam longint unsigned VMASK = (64'd1 << VADDR_BITS) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst = 1'b1;
  logic [NS-1:0]              buf_valid = '0;
  logic [NS-1:0]              buf_ready;
  logic [NS*VADDR_BITS-1:0]   buf_vaddr = '0;
  logic [NS*SIZE_BITS-1:0]    buf_size = '0;
  logic                       req_valid;
  logic                       req_ready = 1'b0;
  logic [VADDR_BITS-1:0]      req_vaddr;
  logic [LEN_BITS-1:0]        req_len;
  logic [STREAM_BITS-1:0]     req_stream;
  logic                       req_last;
  logic                       done_valid;
  logic [STREAM_BITS-1:0]     done_stream;

  mem_chunk_scheduler dut (
    .clk(clk), .rst(rst), .buf_valid(buf_valid), .buf_ready(buf_ready),
    .buf_vaddr(buf_vaddr), .buf_size(buf_size), .req_valid(req_valid),
    .req_ready(req_ready), .req_vaddr(req_vaddr), .req_len(req_len),
    .req_stream(req_stream), .req_last(req_last), .done_valid(done_valid),
    .done_stream(done_stream)
  );

  typedef struct {
    longint unsigned va;
    int unsigned     len;
    int unsigned     st;
    bit              last;
  } chunk_t;

  chunk_t      rq[$];
  int unsigned dq[$];
  int unsigned valid_cycles = 0;
  chunk_t      exp_q[NS][$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Log accepted requests and done pulses as seen on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid) valid_cycles++;
      if (req_valid && req_ready) begin
        chunk_t c;
        c.va = 64'(req_vaddr); c.len = 32'(req_len); c.st = 32'(req_stream); c.last = req_last;
        rq.push_back(c);
      end
      if (done_valid) dq.push_back(32'(done_stream));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not finish, required finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic chunk_t mk(input longint unsigned va, input int unsigned len,
                                input int unsigned st, input bit last);
    chunk_t c;
    c.va = va; c.len = len; c.st = st; c.last = last;
    return c;
  endfunction

  // Reference: cut [va, va+sz) at page boundaries, address wrapping at the top of the space.
  function automatic void model_split(input int unsigned s, input longint unsigned va,
                                      input longint unsigned sz);
    longint unsigned a, rem, room, len;
    a = va & VMASK;
    rem = sz;
    while (rem != 0) begin
      room = longint'(PAGE_BYTES) - (a % longint'(PAGE_BYTES));
      len  = (rem < room) ? rem : room;
      exp_q[s].push_back(mk(a, 32'(len), s, len == rem));
      a   = (a + len) & VMASK;
      rem = rem - len;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; buf_valid = '0; req_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rq.delete(); dq.delete(); valid_cycles = 0;
    for (int s = 0; s < NS; s++) exp_q[s].delete();
  endtask

  task automatic present(input int unsigned s, input longint unsigned va, input int unsigned sz);
    buf_vaddr[s*VADDR_BITS +: VADDR_BITS] = VADDR_BITS'(va);
    buf_size[s*SIZE_BITS +: SIZE_BITS]    = SIZE_BITS'(sz);
    buf_valid[s] = 1'b1;
  endtask

  task automatic load_one(input int unsigned s, input longint unsigned va, input int unsigned sz,
                          output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (buf_ready[s]) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      present(s, va, sz);
      tick();
      buf_valid[s] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    quiet = 0; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (buf_ready == '1 && !req_valid && buf_valid == '0) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; buf_valid = '0; req_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0 || req_last !== 1'b0 || done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got req_valid=%b req_last=%b done_valid=%b required 0 0 0",
               req_valid, req_last, done_valid);
    end
    n_checks++;
    if (buf_ready !== '1) begin
      n_fail++; $display("FAIL reset_buf_ready got %b required all ones", buf_ready);
    end
    n_checks++;
    if (req_vaddr !== '0 || req_len !== '0 || req_stream !== '0 || done_stream !== '0) begin
      n_fail++;
      $display("FAIL reset_fields got vaddr=%0h len=%0d stream=%0d done_stream=%0d required 0 0 0 0",
               req_vaddr, req_len, req_stream, done_stream);
    end
    tick();
  endtask

  task automatic test_aligned();
    chunk_t exp[$];
    bit ok1, ok2;
    do_reset();
    req_ready = 1'b1;
    load_one(0, 64'h1000, 32'h2000, ok1);
    wait_idle(300, ok2);
    exp.push_back(mk(64'h1000, 4096, 0, 1'b0));
    exp.push_back(mk(64'h2000, 4096, 0, 1'b1));
    n_checks++;
    if (!(ok1 && ok2) || rq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL aligned_count got %0d requests (load=%0b idle=%0b) required %0d", rq.size(), ok1, ok2, exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_checks++;
        if (rq[k] != exp[k]) begin
          n_fail++;
          $display("FAIL aligned_req[%0d] got va=%0h len=%0d st=%0d last=%0b required va=%0h len=%0d st=%0d last=%0b",
                   k, rq[k].va, rq[k].len, rq[k].st, rq[k].last, exp[k].va, exp[k].len, exp[k].st, exp[k].last);
        end
      end
    end
    n_checks++;
    if (dq.size() != 1 || dq[0] != 0 || buf_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL aligned_done got %0d pulses first=%0d buf_ready0=%b required 1 pulse stream 0 ready 1",
               dq.size(), (dq.size() > 0) ? dq[0] : 99, buf_ready[0]);
    end
  endtask

  task automatic test_unaligned();
    chunk_t exp[$];
    bit ok1, ok2;
    do_reset();
    req_ready = 1'b1;
    load_one(0, 64'h0F00, 32'h300, ok1);
    wait_idle(300, ok2);
    exp.push_back(mk(64'h0F00, 32'h100, 0, 1'b0));
    exp.push_back(mk(64'h1000, 32'h200, 0, 1'b1));
    n_checks++;
    if (!(ok1 && ok2) || rq.size() != exp.size()) begin
      n_fail++;
      $display("FAIL unaligned_count got %0d requests required %0d", rq.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_checks++;
        if (rq[k] != exp[k]) begin
          n_fail++;
          $display("FAIL unaligned_req[%0d] got va=%0h len=%0h last=%0b required va=%0h len=%0h last=%0b",
                   k, rq[k].va, rq[k].len, rq[k].last, exp[k].va, exp[k].len, exp[k].last);
        end
      end
    end
  endtask

  task automatic test_zero_size();
    bit ok1, ok2;
    int ready_at;
    do_reset();
    req_ready = 1'b1;
    load_one(2, 64'h5000, 0, ok1);
    ready_at = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready_at < 0 && buf_ready[2]) ready_at = c;
    end
    wait_idle(100, ok2);
    n_checks++;
    if (!ok1 || ready_at < 0 || ready_at > 3) begin
      n_fail++; $display("FAIL zero_ready got ready after %0d cycles required within 3", ready_at);
    end
    n_checks++;
    if (valid_cycles != 0 || rq.size() != 0) begin
      n_fail++; $display("FAIL zero_noreq got %0d valid cycles required 0", valid_cycles);
    end
    n_checks++;
    if (!ok2 || dq.size() != 1 || dq[0] != 2) begin
      n_fail++;
      $display("FAIL zero_done got %0d pulse cycles first=%0d required 1 stream 2",
               dq.size(), (dq.size() > 0) ? dq[0] : 99);
    end
  endtask

  task automatic test_fairness();
    int unsigned exp_st[4];
    bit          exp_last[4];
    bit ok;
    exp_st = '{0, 1, 0, 1};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    req_ready = 1'b1;
    present(0, 64'h8000, 32'h2000);
    present(1, 64'hA000, 32'h2000);
    tick();
    buf_valid = '0;
    wait_idle(300, ok);
    n_checks++;
    if (!ok || rq.size() != 4) begin
      n_fail++; $display("FAIL fair_count got %0d requests required 4", rq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rq[k].st != exp_st[k] || rq[k].last != exp_last[k] || rq[k].len != 4096) begin
          n_fail++;
          $display("FAIL fair_req[%0d] got st=%0d last=%0b len=%0d required st=%0d last=%0b len=4096",
                   k, rq[k].st, rq[k].last, rq[k].len, exp_st[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    do_reset();
    req_ready = 1'b0;
    load_one(3, 64'h3000, 32'h1800, ok);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!ok || !seen) begin
      n_fail++; $display("FAIL bp_start got req_valid=%b required 1", req_valid);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_vaddr !== 48'h3000 || req_len !== 13'd4096 ||
          req_stream !== 2'd3 || req_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b va=%0h len=%0d st=%0d last=%b required 1 3000 4096 3 0",
                 k, req_valid, req_vaddr, req_len, req_stream, req_last);
      end
      @(negedge clk);
    end
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rq.size() != 1 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_one got %0d consumed req_valid=%b required 1 consumed valid 0", rq.size(), req_valid);
    end
    tick();
    req_ready = 1'b1;
    wait_idle(300, ok);
    n_checks++;
    if (!ok || rq.size() != 2 || rq[rq.size()-1] != mk(64'h4000, 32'h800, 3, 1'b1)) begin
      n_fail++; $display("FAIL bp_tail got %0d requests required 2 ending (4000,800,3,last)", rq.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    do_reset();
    req_ready = 1'b0;
    load_one(0, 64'h10000, 32'h3000, ok);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid) begin seen = 1'b1; break; end
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || !seen || req_valid !== 1'b0 || buf_ready !== '1 || done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state got seen=%b req_valid=%b buf_ready=%b done=%b required 1 0 all-ones 0",
               seen, req_valid, buf_ready, done_valid);
    end
    tick();
    req_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      n_fail++; $display("FAIL rstmid_drop got %0d requests %0d done required 0 0", rq.size(), dq.size());
    end
    load_one(1, 64'h20000, 32'h100, ok);
    wait_idle(200, seen);
    n_checks++;
    if (!ok || !seen || rq.size() != 1 || rq[0] != mk(64'h20000, 32'h100, 1, 1'b1) ||
        dq.size() != 1 || dq[0] != 1) begin
      n_fail++; $display("FAIL rstmid_fresh got %0d requests %0d done required 1 request (20000,100,1,last) 1 done",
                         rq.size(), dq.size());
    end
  endtask

  task automatic test_random();
    longint unsigned td_va[NS][3];
    int unsigned     td_sz[NS][3];
    int unsigned     td_idx[NS];
    int unsigned     exp_done[NS];
    int unsigned     got_done;
    chunk_t          got[$];
    bit              ok, all_loaded;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      td_idx[s] = 0; exp_done[s] = 0;
      for (int d = 0; d < 3; d++) begin
        case ($urandom_range(0, 5))
          0:       td_va[s][d] = VMASK - 64'($urandom_range(0, 32'h1FFF));
          1:       td_va[s][d] = 64'($urandom_range(0, 255)) << PAGE_SHIFT;
          default: td_va[s][d] = {32'($urandom_range(0, 32'hFFFF)), 32'($urandom)};
        endcase
        td_sz[s][d] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 32'h2800);
      end
    end
    all_loaded = 1'b0;
    for (int c = 0; c < 8000 && !all_loaded; c++) begin
      buf_valid = '0;
      for (int s = 0; s < NS; s++) begin
        if (td_idx[s] < 3 && buf_ready[s] && $urandom_range(0, 3) != 0) begin
          present(s, td_va[s][td_idx[s]], td_sz[s][td_idx[s]]);
          model_split(s, td_va[s][td_idx[s]], longint'(td_sz[s][td_idx[s]]));
          exp_done[s]++;
          td_idx[s]++;
        end
      end
      req_ready = ($urandom_range(0, 2) != 0);
      tick();
      all_loaded = 1'b1;
      for (int s = 0; s < NS; s++) if (td_idx[s] < 3) all_loaded = 1'b0;
    end
    buf_valid = '0;
    req_ready = 1'b1;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok || !all_loaded) begin
      n_fail++; $display("FAIL rand_drain got loaded=%b idle=%b required 1 1", all_loaded, ok);
    end
    for (int s = 0; s < NS; s++) begin
      got.delete();
      got_done = 0;
      foreach (rq[k]) if (rq[k].st == s) got.push_back(rq[k]);
      foreach (dq[k]) if (dq[k] == s) got_done++;
      n_checks++;
      if (got.size() != exp_q[s].size() || got_done != exp_done[s]) begin
        n_fail++;
        $display("FAIL rand_count[s%0d] got %0d chunks %0d done required %0d chunks %0d done",
                 s, got.size(), got_done, exp_q[s].size(), exp_done[s]);
      end else begin
        for (int k = 0; k < got.size(); k++) begin
          n_checks++;
          if (got[k] != exp_q[s][k]) begin
            n_fail++;
            $display("FAIL rand_req[s%0d:%0d] got va=%0h len=%0h last=%0b required va=%0h len=%0h last=%0b",
                     s, k, got[k].va, got[k].len, got[k].last,
                     exp_q[s][k].va, exp_q[s][k].len, exp_q[s][k].last);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_zero_size();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    for (int r = 0; r < 3; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_chunk_scheduler.md
Name: mem_chunk_scheduler

Overview:
- Consumes per-stream buffer descriptors (virtual address and allocation size) produced by the memory configuration block.
- Splits each buffer into page-bounded memory requests and interleaves the streams round-robin onto one shared request port.
- Sits between the configuration front end and the memory/DMA request engine.
- Reports completion of each buffer on a per-stream done pulse.

Parameters:
- NUM_STREAMS, 4, number of independent buffer streams (>=1).
- VADDR_BITS, 48, virtual address width.
- SIZE_BITS, 28, buffer size width in bytes.
- PAGE_BYTES, 4096, page/chunk boundary; power of two. No request crosses it.
- LEN_BITS, $clog2(PAGE_BYTES)+1, request length width.
- STREAM_BITS, max(1,$clog2(NUM_STREAMS)), stream index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- buf_valid  in  NUM_STREAMS  descriptor valid, one bit per stream.
- buf_ready  out  NUM_STREAMS  descriptor slot empty, per stream.
- buf_vaddr  in  NUM_STREAMS*VADDR_BITS  start address per stream.
- buf_size  in  NUM_STREAMS*SIZE_BITS  byte count per stream.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_vaddr  out  VADDR_BITS  chunk start address.
- req_len  out  LEN_BITS  chunk length in bytes, 1..PAGE_BYTES.
- req_stream  out  STREAM_BITS  owning stream.
- req_last  out  1  final chunk of the buffer.
- done_valid  out  1  single-cycle pulse when a buffer completes.
- done_stream  out  STREAM_BITS  stream that completed.

Behaviour:
- Slots: one descriptor slot per stream holding occupied, cur_vaddr and remaining.
  - buf_ready[i] is a register equal to !occupied[i].
  - Handshake on stream i (buf_valid[i] && buf_ready[i]) loads the slot; it is occupied from the next cycle.
- Freed-slot timing: a slot freed in cycle k shows buf_ready high in cycle k+1. There is no same-cycle refill.
- FSM states: IDLE and ISSUE.
  - IDLE: if any slot is occupied, the round-robin arbiter grants one and the request registers are loaded; next state is ISSUE. Otherwise stay in IDLE.
  - ISSUE: req_valid=1. All req_* fields stay stable until req_ready. On handshake, go to IDLE.
  - Throughput: at most one chunk per 2 cycles.
- Chunk length: len = min(remaining, PAGE_BYTES - (cur_vaddr mod PAGE_BYTES)).
  - Compute in SIZE_BITS+1 width so there is no truncation.
  - req_last = (len == remaining).
- On request handshake:
  - cur_vaddr += len; remaining -= len.
  - If req_last: clear the slot, then done_valid=1 and done_stream=stream in the following cycle.
- Zero-size buffer:
  - Accepted normally; no request is issued.
  - The IDLE grant of that slot frees it and pulses done next cycle; FSM stays in IDLE.
- Arbitration:
  - Round-robin pointer starts at 0.
  - After every grant, pointer = granted+1 (mod NUM_STREAMS).
  - Streams interleave per chunk, not per buffer.
- Address wrap: cur_vaddr wraps modulo 2^VADDR_BITS; no error is raised.
- Latency: descriptor accepted at edge N gives req_valid high in cycle N+2, for both chunk computation and grant.
- Reset (any time, including mid-request):
  - All slots cleared; buf_ready all 1 from the cycle after reset deasserts.
  - req_valid=0, req_* fields=0, req_last=0.
  - done_valid=0, done_stream=0.
  - Pointer=0, FSM=IDLE.
  - The in-flight chunk is dropped.

Decomposition:
- Shared package holds:
  - Existing vaddress_t and alloc_size_t.
  - New PAGE_BYTES constant.
  - mem_req_t struct {vaddr, len, stream, last}.
- One sub-module: round_robin_arbiter.
  - Interface: request vector, pointer, grant one-hot/index, grant_valid.
  - Combinational, with the pointer register kept in this block.

Test Plan:
- Aligned multi-page: PAGE_BYTES=4096, stream 0, vaddr 0x1000, size 0x2000, req_ready=1.
  - Requests (0x1000,4096,last=0) then (0x2000,4096,last=1).
  - Then done_valid with done_stream=0; buf_ready[0] returns high.
- Unaligned: vaddr 0x0F00, size 0x300.
  - Requests (0x0F00,0x100,last=0) then (0x1000,0x200,last=1).
- Zero size: stream 2, vaddr 0x5000, size 0.
  - No req_valid.
  - One-cycle done_valid with done_stream=2; buf_ready[2] high again within 3 cycles.
- Fairness: streams 0 and 1 loaded in the same cycle, each with vaddr aligned and size 0x2000.
  - req_stream order is 0,1,0,1; last=1 on the 3rd and 4th requests.
- Backpressure: hold req_ready=0 for 5 cycles during a request.
  - req_valid and all req_* fields unchanged each cycle; exactly one chunk consumed when ready rises.
- Reset mid-operation: assert rst during ISSUE of the 1st chunk of a 3-page buffer.
  - Next cycle: req_valid=0, all buf_ready=1.
  - No done pulse.
  - A fresh descriptor after reset issues from its own vaddr.
